coder_block_scheduler: RTL and testbench
========================================

// Module: coder_block_scheduler
// PURPOSE
//  Sequences an image's worth of blocks into CODER: per block it forwards one d_flag, then exactly
//  2^BLOCK_SIZE_LOG ehat and 2^BLOCK_SIZE_LOG kj words (coded blocks) or drains them (skipped blocks).
//  After NUM_BLOCKS blocks it pulses CODER flush, waits for flushed and reports done.
//  Sits between the predictor/parameter stages and the CODER instance.
// PARAMETERS
//  MAPPED_ERROR_WIDTH  19  ehat word width
//  ACC_LOG             5   kj word width
//  BLOCK_SIZE_LOG      8   log2 samples per block (block = 256 samples)
//  BLOCK_COUNT_WIDTH   16  width of num_blocks / block counter
// PORTS
//  clk             in   1                   clock, all logic on rising edge
//  rst             in   1                   asynchronous, active-low reset
//  start           in   1                   1-cycle pulse in IDLE: latch num_blocks, begin image
//  num_blocks      in   BLOCK_COUNT_WIDTH   blocks in image; 0 -> flush only
//  busy            out  1                   1 in any state but IDLE
//  done            out  1                   1-cycle pulse when flushed is seen
//  dflag_in_*      in/out 1 / valid,ready   upstream d_flag stream (AXI-S)
//  ehat_in_*       in/out MAPPED_ERROR_WIDTH upstream ehat stream (AXI-S)
//  kj_in_*         in/out ACC_LOG           upstream kj stream (AXI-S)
//  d_flag_out_*    out/in 1                 to CODER d_flag port
//  ehat_out_*      out/in MAPPED_ERROR_WIDTH to CODER ehat port
//  kj_out_*        out/in ACC_LOG           to CODER kj port
//  flush           out  1                   to CODER; 1-cycle pulse
//  flushed         in   1                   from CODER; flush complete
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, counters=0, busy=0, done=0, flush=0, all out_valid=0,
//   all in_ready=0. Mid-operation reset aborts the image; no flush issued.
//  FSM: IDLE -start-> (num_blocks==0 ? FLUSH : FLAG). FLAG -dflag transfer-> flag=1 ? CODE : DRAIN.
//   CODE/DRAIN -both per-block counts reached-> (blk==num_blocks-1 ? FLUSH : FLAG), blk++.
//   FLUSH (1 cycle, flush=1) -> WAIT. WAIT -flushed=1-> IDLE with done=1 that cycle.
//  start outside IDLE is ignored. num_blocks latched at start; later changes ignored.
//  FLAG: d_flag_out_valid=dflag_in_valid, dflag_in_ready=d_flag_out_ready (combinational
//   pass-through); flag value registered on the transfer. ehat/kj paths closed.
//  CODE: ehat and kj paths independent pass-throughs, each with own counter (0..2^BLOCK_SIZE_LOG);
//   a path closes (valid/ready=0) once its counter hits 2^BLOCK_SIZE_LOG; block ends the cycle the
//   second path completes its last transfer. dflag path closed.
//  DRAIN: ehat_in_ready=1, kj_in_ready=1 until each count reaches 2^BLOCK_SIZE_LOG;
//   ehat_out_valid=kj_out_valid=0; data discarded.
//  Counters are BLOCK_SIZE_LOG+1 bits, cleared on block end; blk counter cleared in IDLE.
//  No added latency: forwarded data is combinational, zero-cycle. No in_valid->in_ready
//   combinational path (ready depends only on state, counters and out_ready).
//  Last block: FLUSH entered on the cycle after the final transfer; flush high exactly 1 cycle.
//  flushed asserted outside WAIT is ignored. dflag/ehat/kj arriving in IDLE/FLUSH/WAIT stall.
// TESTING
//  1) num_blocks=2, flags {1,1}, ehat=0..511, kj=k mod 32, CODER always ready -> 2 d_flag,
//     512 ehat, 512 kj out, in order; one flush pulse; done 1 cycle after flushed.
//  2) num_blocks=3, flags {1,0,1} -> 3 d_flag out; ehat/kj out only for blocks 0 and 2 (512 each);
//     block 1's 256+256 words consumed, never forwarded.
//  3) Random backpressure on ehat_out_ready/kj_out_ready, random in_valid gaps, 4 blocks ->
//     no loss/duplication; kj path finishing 100 cycles before ehat holds kj closed until block end.
//  4) num_blocks=0, start -> flush next cycle, no stream traffic, done after flushed.
//  5) rst=0 during CODE at sample 100 of block 1 -> all outputs to reset values same cycle;
//     new start afterwards runs a full image from block 0.
//  6) start pulsed while busy, flushed pulsed in CODE -> both ignored; sequence unchanged.

Source files
------------

// File: rtl/coder_block_scheduler.sv
// Block-level sequencer in front of CODER: forwards one d_flag per block, then either forwards
// (coded) or discards (skipped) one block of ehat/kj words; flushes CODER after the last block.
module coder_block_scheduler #(
    parameter int unsigned MAPPED_ERROR_WIDTH = 19,
    parameter int unsigned ACC_LOG            = 5,
    parameter int unsigned BLOCK_SIZE_LOG     = 8,
    parameter int unsigned BLOCK_COUNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BLOCK_COUNT_WIDTH-1:0]  num_blocks,
    output logic                          busy,
    output logic                          done,

    input  logic                          dflag_in_data,
    input  logic                          dflag_in_valid,
    output logic                          dflag_in_ready,
    input  logic [MAPPED_ERROR_WIDTH-1:0] ehat_in_data,
    input  logic                          ehat_in_valid,
    output logic                          ehat_in_ready,
    input  logic [ACC_LOG-1:0]            kj_in_data,
    input  logic                          kj_in_valid,
    output logic                          kj_in_ready,

    output logic                          d_flag_out_data,
    output logic                          d_flag_out_valid,
    input  logic                          d_flag_out_ready,
    output logic [MAPPED_ERROR_WIDTH-1:0] ehat_out_data,
    output logic                          ehat_out_valid,
    input  logic                          ehat_out_ready,
    output logic [ACC_LOG-1:0]            kj_out_data,
    output logic                          kj_out_valid,
    input  logic                          kj_out_ready,

    output logic                          flush,
    input  logic                          flushed
);

    localparam int unsigned CNT_W = BLOCK_SIZE_LOG + 1;
    localparam logic [CNT_W-1:0] BLOCK_LEN = {1'b1, {BLOCK_SIZE_LOG{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLAG,
        S_CODE,
        S_DRAIN,
        S_FLUSH,
        S_WAIT
    } state_t;

    state_t                       state, state_d;
    logic [CNT_W-1:0]             ehat_cnt, ehat_cnt_d;
    logic [CNT_W-1:0]             kj_cnt, kj_cnt_d;
    logic [BLOCK_COUNT_WIDTH-1:0] blk, blk_d;
    logic [BLOCK_COUNT_WIDTH-1:0] num_q, num_d;
    logic                         done_d;

    logic                         ehat_open, kj_open;
    logic                         ehat_xfer, kj_xfer;
    logic [CNT_W-1:0]             ehat_cnt_inc, kj_cnt_inc;
    logic                         ehat_fin, kj_fin;
    logic                         last_blk;

    // State, counters and the registered done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            ehat_cnt <= '0;
            kj_cnt   <= '0;
            blk      <= '0;
            num_q    <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            ehat_cnt <= ehat_cnt_d;
            kj_cnt   <= kj_cnt_d;
            blk      <= blk_d;
            num_q    <= num_d;
            done     <= done_d;
        end
    end

    // Data buses are pure wires; only the handshakes are gated by state
    assign d_flag_out_data = dflag_in_data;
    assign ehat_out_data   = ehat_in_data;
    assign kj_out_data     = kj_in_data;

    assign busy     = (state != S_IDLE);
    assign flush    = (state == S_FLUSH);
    assign last_blk = (blk == (num_q - BLOCK_COUNT_WIDTH'(1)));

    assign ehat_open = (ehat_cnt != BLOCK_LEN);
    assign kj_open   = (kj_cnt != BLOCK_LEN);

    // Next-state and handshake decode
    always_comb begin
        state_d          = state;
        ehat_cnt_d       = ehat_cnt;
        kj_cnt_d         = kj_cnt;
        blk_d            = blk;
        num_d            = num_q;
        done_d           = 1'b0;
        dflag_in_ready   = 1'b0;
        d_flag_out_valid = 1'b0;
        ehat_in_ready    = 1'b0;
        ehat_out_valid   = 1'b0;
        kj_in_ready      = 1'b0;
        kj_out_valid     = 1'b0;
        ehat_xfer        = 1'b0;
        kj_xfer          = 1'b0;
        ehat_cnt_inc     = ehat_cnt;
        kj_cnt_inc       = kj_cnt;
        ehat_fin         = 1'b0;
        kj_fin           = 1'b0;

        case (state)
            S_IDLE: begin
                blk_d      = '0;
                ehat_cnt_d = '0;
                kj_cnt_d   = '0;
                if (start) begin
                    num_d   = num_blocks;
                    state_d = (num_blocks == '0) ? S_FLUSH : S_FLAG;
                end
            end

            S_FLAG: begin
                d_flag_out_valid = dflag_in_valid;
                dflag_in_ready   = d_flag_out_ready;
                if (dflag_in_valid && d_flag_out_ready) begin
                    state_d = dflag_in_data ? S_CODE : S_DRAIN;
                end
            end

            S_CODE, S_DRAIN: begin
                if (state == S_CODE) begin
                    ehat_out_valid = ehat_in_valid & ehat_open;
                    ehat_in_ready  = ehat_out_ready & ehat_open;
                    kj_out_valid   = kj_in_valid & kj_open;
                    kj_in_ready    = kj_out_ready & kj_open;
                end else begin
                    ehat_in_ready  = ehat_open;
                    kj_in_ready    = kj_open;
                end
                ehat_xfer    = ehat_in_valid & ehat_in_ready;
                kj_xfer      = kj_in_valid & kj_in_ready;
                ehat_cnt_inc = ehat_cnt + CNT_W'(ehat_xfer);
                kj_cnt_inc   = kj_cnt + CNT_W'(kj_xfer);
                ehat_fin     = (ehat_cnt_inc == BLOCK_LEN);
                kj_fin       = (kj_cnt_inc == BLOCK_LEN);
                // Block ends on the cycle the slower path completes its last word
                if (ehat_fin && kj_fin) begin
                    ehat_cnt_d = '0;
                    kj_cnt_d   = '0;
                    blk_d      = blk + BLOCK_COUNT_WIDTH'(1);
                    state_d    = last_blk ? S_FLUSH : S_FLAG;
                end else begin
                    ehat_cnt_d = ehat_cnt_inc;
                    kj_cnt_d   = kj_cnt_inc;
                end
            end

            S_FLUSH: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (flushed) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_coder_block_scheduler.sv
// Randomised scoreboard bench for coder_block_scheduler: sources, sinks and a CODER flush
// responder run as free processes; a monitor pops expected words on every output transfer.
module tb_coder_block_scheduler;

    localparam int unsigned MEW  = 19;
    localparam int unsigned AL   = 5;
    localparam int unsigned BSL  = 8;
    localparam int unsigned BCW  = 16;
    localparam int          BLEN = 1 << BSL;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [BCW-1:0] num_blocks = '0;
    logic           busy, done;
    logic           dflag_in_data = 1'b0, dflag_in_valid = 1'b0, dflag_in_ready;
    logic [MEW-1:0] ehat_in_data = '0;
    logic           ehat_in_valid = 1'b0, ehat_in_ready;
    logic [AL-1:0]  kj_in_data = '0;
    logic           kj_in_valid = 1'b0, kj_in_ready;
    logic           d_flag_out_data, d_flag_out_valid, d_flag_out_ready = 1'b0;
    logic [MEW-1:0] ehat_out_data;
    logic           ehat_out_valid, ehat_out_ready = 1'b0;
    logic [AL-1:0]  kj_out_data;
    logic           kj_out_valid, kj_out_ready = 1'b0;
    logic           flush;
    logic           flushed = 1'b0;

    coder_block_scheduler #(
        .MAPPED_ERROR_WIDTH(MEW), .ACC_LOG(AL), .BLOCK_SIZE_LOG(BSL), .BLOCK_COUNT_WIDTH(BCW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks), .busy(busy), .done(done),
        .dflag_in_data(dflag_in_data), .dflag_in_valid(dflag_in_valid), .dflag_in_ready(dflag_in_ready),
        .ehat_in_data(ehat_in_data), .ehat_in_valid(ehat_in_valid), .ehat_in_ready(ehat_in_ready),
        .kj_in_data(kj_in_data), .kj_in_valid(kj_in_valid), .kj_in_ready(kj_in_ready),
        .d_flag_out_data(d_flag_out_data), .d_flag_out_valid(d_flag_out_valid),
        .d_flag_out_ready(d_flag_out_ready),
        .ehat_out_data(ehat_out_data), .ehat_out_valid(ehat_out_valid), .ehat_out_ready(ehat_out_ready),
        .kj_out_data(kj_out_data), .kj_out_valid(kj_out_valid), .kj_out_ready(kj_out_ready),
        .flush(flush), .flushed(flushed)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic d; int blk; } fw_t;
    typedef struct packed { logic [MEW-1:0] d; int blk; } ew_t;
    typedef struct packed { logic [AL-1:0] d; int blk; } kw_t;

    logic           src_flag[$];
    logic [MEW-1:0] src_ehat[$];
    logic [AL-1:0]  src_kj[$];
    fw_t            exp_flag[$];
    ew_t            exp_ehat[$];
    kw_t            exp_kj[$];

    int n_vec = 0;
    int n_err = 0;
    int gap_pct = 0, bpe_pct = 0, bpk_pct = 0, bpf_pct = 0;
    int mon_blk = 0, mon_ecnt = 0, flush_cnt = 0, done_cnt = 0;
    logic f_acc = 1'b0, e_acc = 1'b0, k_acc = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Source handshake sampling, mid-cycle
    initial forever begin
        @(negedge clk);
        f_acc = dflag_in_valid && dflag_in_ready;
        e_acc = ehat_in_valid && ehat_in_ready;
        k_acc = kj_in_valid && kj_in_ready;
    end

    // Upstream sources (valid held until accepted) and CODER sink readiness
    initial forever begin
        @(posedge clk);
        #1;
        if (!(dflag_in_valid && !f_acc)) begin
            if (f_acc && src_flag.size() > 0) void'(src_flag.pop_front());
            dflag_in_valid = (src_flag.size() > 0) && ($urandom_range(99) >= gap_pct);
            if (dflag_in_valid) dflag_in_data = src_flag[0];
        end
        if (!(ehat_in_valid && !e_acc)) begin
            if (e_acc && src_ehat.size() > 0) void'(src_ehat.pop_front());
            ehat_in_valid = (src_ehat.size() > 0) && ($urandom_range(99) >= gap_pct);
            if (ehat_in_valid) ehat_in_data = src_ehat[0];
        end
        if (!(kj_in_valid && !k_acc)) begin
            if (k_acc && src_kj.size() > 0) void'(src_kj.pop_front());
            kj_in_valid = (src_kj.size() > 0) && ($urandom_range(99) >= gap_pct);
            if (kj_in_valid) kj_in_data = src_kj[0];
        end
        f_acc = 1'b0;
        e_acc = 1'b0;
        k_acc = 1'b0;
        d_flag_out_ready = ($urandom_range(99) >= bpf_pct);
        ehat_out_ready   = ($urandom_range(99) >= bpe_pct);
        kj_out_ready     = ($urandom_range(99) >= bpk_pct);
    end

    // CODER flush responder
    initial forever begin
        @(negedge clk);
        if (rst && flush) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1 flushed = 1'b1;
            @(posedge clk);
            #1 flushed = 1'b0;
        end
    end

    // Output monitor / scoreboard
    initial begin
        fw_t  fw;
        ew_t  ew;
        kw_t  kw;
        logic prev_flush = 1'b0, prev_flushed = 1'b0, prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (d_flag_out_valid && d_flag_out_ready) begin
                    if (exp_flag.size() == 0) begin
                        check("dflag_unexpected", 1, 0);
                    end else begin
                        fw = exp_flag.pop_front();
                        check("dflag_value", longint'(d_flag_out_data), longint'(fw.d));
                        if (exp_ehat.size() > 0) check("ehat_leftover_at_flag", longint'(exp_ehat[0].blk >= mon_blk), 1);
                        if (exp_kj.size() > 0) check("kj_leftover_at_flag", longint'(exp_kj[0].blk >= mon_blk), 1);
                        mon_blk++;
                        mon_ecnt = 0;
                    end
                end
                if (ehat_out_valid && ehat_out_ready) begin
                    if (exp_ehat.size() == 0) begin
                        check("ehat_unexpected", 1, 0);
                    end else begin
                        ew = exp_ehat.pop_front();
                        check("ehat_data", longint'(ehat_out_data), longint'(ew.d));
                        check("ehat_block", longint'(mon_blk - 1), longint'(ew.blk));
                    end
                    mon_ecnt++;
                end
                if (kj_out_valid && kj_out_ready) begin
                    if (exp_kj.size() == 0) begin
                        check("kj_unexpected", 1, 0);
                    end else begin
                        kw = exp_kj.pop_front();
                        check("kj_data", longint'(kj_out_data), longint'(kw.d));
                        check("kj_block", longint'(mon_blk - 1), longint'(kw.blk));
                    end
                end
                if (flush) begin
                    flush_cnt++;
                    check("flush_width", longint'(prev_flush), 0);
                    check("flush_pending", longint'(exp_flag.size() + exp_ehat.size() + exp_kj.size()), 0);
                end
                if (done) begin
                    done_cnt++;
                    check("done_after_flushed", longint'(prev_flushed), 1);
                    check("done_width", longint'(prev_done), 0);
                end
            end
            prev_flush   = flush;
            prev_flushed = flushed;
            prev_done    = done;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_flush"}, longint'(flush), 0);
        check({tag, "_dflag_out_valid"}, longint'(d_flag_out_valid), 0);
        check({tag, "_ehat_out_valid"}, longint'(ehat_out_valid), 0);
        check({tag, "_kj_out_valid"}, longint'(kj_out_valid), 0);
        check({tag, "_dflag_in_ready"}, longint'(dflag_in_ready), 0);
        check({tag, "_ehat_in_ready"}, longint'(ehat_in_ready), 0);
        check({tag, "_kj_in_ready"}, longint'(kj_in_ready), 0);
    endtask

    // Reference model: every d_flag goes through; ehat/kj survive only for flagged blocks
    task automatic load_image(input int n, input logic [15:0] flags, input bit seq);
        logic [MEW-1:0] e;
        logic [AL-1:0]  k;
        for (int b = 0; b < n; b++) begin
            src_flag.push_back(flags[b]);
            exp_flag.push_back('{flags[b], b});
            for (int i = 0; i < BLEN; i++) begin
                e = seq ? MEW'(b * BLEN + i) : MEW'($urandom);
                k = seq ? AL'((b * BLEN + i) % 32) : AL'($urandom);
                src_ehat.push_back(e);
                src_kj.push_back(k);
                if (flags[b]) begin
                    exp_ehat.push_back('{e, b});
                    exp_kj.push_back('{k, b});
                end
            end
        end
    endtask

    task automatic start_image(input int n);
        mon_blk  = 0;
        mon_ecnt = 0;
        repeat (3) @(negedge clk);
        check("idle_busy", longint'(busy), 0);
        check("idle_dflag_stall", longint'(dflag_in_ready), 0);
        check("idle_ehat_stall", longint'(ehat_in_ready), 0);
        @(posedge clk);
        #1 num_blocks = BCW'(n);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        num_blocks = BCW'($urandom);
        @(negedge clk);
        check("flush_after_start", longint'(flush), longint'(n == 0));
        check("busy_after_start", longint'(busy), 1);
    endtask

    task automatic run_image(input int n, input logic [15:0] flags, input bit seq, input bit inject);
        int f0, d0, cyc;
        bit injected;
        f0 = flush_cnt;
        d0 = done_cnt;
        injected = 1'b0;
        load_image(n, flags, seq);
        start_image(n);
        cyc = 0;
        while (done_cnt == d0 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (inject && !injected && mon_blk == 1 && mon_ecnt >= 50) begin
                injected = 1'b1;
                @(posedge clk);
                #1 start = 1'b1;
                flushed = 1'b1;
                num_blocks = BCW'(7);
                @(posedge clk);
                #1 start = 1'b0;
                flushed = 1'b0;
            end
        end
        check("done_within_budget", longint'(cyc < 30000), 1);
        repeat (3) @(negedge clk);
        check("flush_pulses", longint'(flush_cnt - f0), 1);
        check("done_pulses", longint'(done_cnt - d0), 1);
        check("flags_seen", longint'(mon_blk), longint'(n));
        check("exp_left", longint'(exp_flag.size() + exp_ehat.size() + exp_kj.size()), 0);
        check("src_left", longint'(src_flag.size() + src_ehat.size() + src_kj.size()), 0);
        check("idle_after_done", longint'(busy), 0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #2 rst = 1'b1;

        // Coded blocks with sequential data, no stalls
        run_image(2, 16'b11, 1'b1, 1'b0);
        // Middle block skipped
        run_image(3, 16'b101, 1'b1, 1'b0);
        // Random flags, gaps and backpressure
        gap_pct = 30; bpe_pct = 50; bpk_pct = 50; bpf_pct = 30;
        run_image(4, 16'($urandom), 1'b0, 1'b0);
        // kj path runs far ahead of ehat
        gap_pct = 0; bpe_pct = 75; bpk_pct = 0; bpf_pct = 0;
        run_image(2, 16'b11, 1'b0, 1'b0);
        // Empty image
        run_image(0, 16'b0, 1'b0, 1'b0);

        // Abort during block 1, then a complete image from block 0
        gap_pct = 10; bpe_pct = 20; bpk_pct = 20; bpf_pct = 10;
        load_image(3, 16'b111, 1'b0);
        start_image(3);
        cyc = 0;
        while (!(mon_blk == 2 && mon_ecnt >= 100) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_block1_sample100", longint'(cyc < 20000), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midrst");
        src_flag.delete(); src_ehat.delete(); src_kj.delete();
        exp_flag.delete(); exp_ehat.delete(); exp_kj.delete();
        dflag_in_valid = 1'b0; ehat_in_valid = 1'b0; kj_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        run_image(2, 16'b11, 1'b0, 1'b0);

        // Stray start and flushed while coding
        run_image(3, 16'b011, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
